// File: rtl/ttc_pkg.sv
// Shared types and default constants for the TTC L0/L1 pulse-width decoder.
package ttc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        HIGH  = 3'b010,
        STUCK = 3'b100
    } meas_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        ERR  = 2'd3
    } pulse_class_e;

    localparam int DEF_L0_LEN     = 1;
    localparam int DEF_L1_LEN     = 2;
    localparam int DEF_MAX_LEN    = 7;
    localparam int DEF_LAT_W      = 9;
    localparam int DEF_L1_LAT_MIN = 240;
    localparam int DEF_L1_LAT_MAX = 280;
    localparam int DEF_CNT_W      = 32;

    // Bits needed to hold a run length of 0..max_len.
    function automatic int run_width(input int max_len);
        return (max_len < 1) ? 1 : $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/ttc_pulse_meas.sv
// Run-length FSM on the L1accept line; emits a one-cycle registered
// classification of every completed high run.
module ttc_pulse_meas
    import ttc_pkg::*;
#(
    parameter int L0_LEN  = DEF_L0_LEN,
    parameter int L1_LEN  = DEF_L1_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig_en,
    input  logic       line_in,
    output logic [1:0] pulse_cls
);

    localparam int RUN_W = run_width(MAX_LEN);

    meas_state_e      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    pulse_class_e     cls_q, cls_d;

    function automatic pulse_class_e classify(input logic [RUN_W-1:0] len);
        if (len == RUN_W'(L0_LEN)) begin
            return L0;
        end else if (len == RUN_W'(L1_LEN)) begin
            return L1;
        end else begin
            return ERR;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cls_d   = NONE;
        if (!trig_en) begin
            state_d = IDLE;
            run_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_in) begin
                        state_d = HIGH;
                        run_d   = RUN_W'(1);
                    end
                end
                HIGH: begin
                    if (line_in) begin
                        // Error is raised once on entry; STUCK stays silent.
                        if (run_q == RUN_W'(MAX_LEN)) begin
                            state_d = STUCK;
                            run_d   = '0;
                            cls_d   = ERR;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                        cls_d   = classify(run_q);
                    end
                end
                STUCK: begin
                    if (!line_in) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            cls_q   <= NONE;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cls_q   <= cls_d;
        end
    end

    assign pulse_cls = cls_q;

endmodule

// File: rtl/ttc_trig_pulse_decoder.sv
// TTC channel-A L0/L1 decoder: pulse-width classification, L0->L1 latency
// window check and saturating statistics counters for the SRU status block.
module ttc_trig_pulse_decoder
    import ttc_pkg::*;
#(
    parameter int L0_LEN     = DEF_L0_LEN,
    parameter int L1_LEN     = DEF_L1_LEN,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LAT_W      = DEF_LAT_W,
    parameter int L1_LAT_MIN = DEF_L1_LAT_MIN,
    parameter int L1_LAT_MAX = DEF_L1_LAT_MAX,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             gclk_40m,
    input  logic             reset,
    input  logic             ttc_l1accept,
    input  logic             trig_en,
    input  logic             cnt_clr,
    output logic             ttc_l0,
    output logic             ttc_l1,
    output logic             ttc_pulse_err,
    output logic             ttc_l1_lat_err,
    output logic [LAT_W-1:0] l1_lat,
    output logic [CNT_W-1:0] l0_cnt,
    output logic [CNT_W-1:0] l1_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic [1:0] pulse_cls;

    ttc_pulse_meas #(
        .L0_LEN  (L0_LEN),
        .L1_LEN  (L1_LEN),
        .MAX_LEN (MAX_LEN)
    ) u_meas (
        .clk       (gclk_40m),
        .reset     (reset),
        .trig_en   (trig_en),
        .line_in   (ttc_l1accept),
        .pulse_cls (pulse_cls)
    );

    logic l0_hit, l1_hit, perr_hit, lat_err;

    // Strobes are masked the moment decoding is disabled.
    assign l0_hit   = trig_en && (pulse_cls == L0);
    assign l1_hit   = trig_en && (pulse_cls == L1);
    assign perr_hit = trig_en && (pulse_cls == ERR);

    logic [LAT_W-1:0] lat_q, lat_d;
    logic             win_open_q, win_open_d;
    logic [LAT_W-1:0] l1_lat_q, l1_lat_d;
    logic             in_window;
    logic [LAT_W-1:0] lat_now;

    assign in_window = win_open_q && (lat_q <= LAT_W'(L1_LAT_MAX));
    assign lat_now   = in_window ? lat_q : '0;
    assign lat_err   = l1_hit && (!in_window || (lat_q < LAT_W'(L1_LAT_MIN)));

    always_comb begin
        lat_d      = lat_q;
        win_open_d = win_open_q;
        l1_lat_d   = l1_lat_q;
        if (win_open_q && (lat_q != '1)) begin
            lat_d = lat_q + LAT_W'(1);
        end
        if (win_open_q && (lat_q > LAT_W'(L1_LAT_MAX))) begin
            win_open_d = 1'b0;
        end
        if (l1_hit) begin
            win_open_d = 1'b0;
            l1_lat_d   = lat_now;
        end
        // A fresh L0 always restarts the window, even if one is open.
        if (l0_hit) begin
            win_open_d = 1'b1;
            lat_d      = LAT_W'(1);
        end
        if (!trig_en) begin
            win_open_d = 1'b0;
        end
    end

    always_ff @(posedge gclk_40m) begin
        if (reset) begin
            lat_q      <= '0;
            win_open_q <= 1'b0;
            l1_lat_q   <= '0;
        end else begin
            lat_q      <= lat_d;
            win_open_q <= win_open_d;
            l1_lat_q   <= l1_lat_d;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] l0_cnt_q, l0_cnt_d;
    logic [CNT_W-1:0] l1_cnt_q, l1_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        l0_cnt_d  = l0_cnt_q;
        l1_cnt_d  = l1_cnt_q;
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            l0_cnt_d  = '0;
            l1_cnt_d  = '0;
            err_cnt_d = '0;
        end else begin
            if (l0_hit) begin
                l0_cnt_d = sat_inc(l0_cnt_q);
            end
            if (l1_hit) begin
                l1_cnt_d = sat_inc(l1_cnt_q);
            end
            if (perr_hit || lat_err) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
    end

    always_ff @(posedge gclk_40m) begin
        if (reset) begin
            l0_cnt_q  <= '0;
            l1_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            l0_cnt_q  <= l0_cnt_d;
            l1_cnt_q  <= l1_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ttc_l0         = l0_hit;
    assign ttc_l1         = l1_hit;
    assign ttc_pulse_err  = perr_hit;
    assign ttc_l1_lat_err = lat_err;
    assign l1_lat         = l1_hit ? lat_now : l1_lat_q;
    assign l0_cnt         = l0_cnt_q;
    assign l1_cnt         = l1_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_ttc_trig_pulse_decoder.sv
// Directed bench for ttc_trig_pulse_decoder: per-cycle stimulus tables with
// hand-derived strobe timing, latencies and counter values.
module tb_ttc_trig_pulse_decoder;

    localparam int N = 520;

    logic gclk_40m = 1'b0;
    logic reset = 1'b1;
    logic ttc_l1accept = 1'b0;
    logic trig_en = 1'b1;
    logic cnt_clr = 1'b0;

    logic        ttc_l0, ttc_l1, ttc_pulse_err, ttc_l1_lat_err;
    logic [8:0]  l1_lat;
    logic [31:0] l0_cnt, l1_cnt, err_cnt;

    logic        ttc_l0_4, ttc_l1_4, ttc_pulse_err_4, ttc_l1_lat_err_4;
    logic [8:0]  l1_lat_4;
    logic [3:0]  l0_cnt_4, l1_cnt_4, err_cnt_4;

    ttc_trig_pulse_decoder dut (
        .gclk_40m       (gclk_40m),
        .reset          (reset),
        .ttc_l1accept   (ttc_l1accept),
        .trig_en        (trig_en),
        .cnt_clr        (cnt_clr),
        .ttc_l0         (ttc_l0),
        .ttc_l1         (ttc_l1),
        .ttc_pulse_err  (ttc_pulse_err),
        .ttc_l1_lat_err (ttc_l1_lat_err),
        .l1_lat         (l1_lat),
        .l0_cnt         (l0_cnt),
        .l1_cnt         (l1_cnt),
        .err_cnt        (err_cnt)
    );

    ttc_trig_pulse_decoder #(.CNT_W(4)) dut4 (
        .gclk_40m       (gclk_40m),
        .reset          (reset),
        .ttc_l1accept   (ttc_l1accept),
        .trig_en        (trig_en),
        .cnt_clr        (cnt_clr),
        .ttc_l0         (ttc_l0_4),
        .ttc_l1         (ttc_l1_4),
        .ttc_pulse_err  (ttc_pulse_err_4),
        .ttc_l1_lat_err (ttc_l1_lat_err_4),
        .l1_lat         (l1_lat_4),
        .l0_cnt         (l0_cnt_4),
        .l1_cnt         (l1_cnt_4),
        .err_cnt        (err_cnt_4)
    );

    always #5 gclk_40m = ~gclk_40m;

    int checks = 0;
    int passes = 0;

    logic        pat_a [N];
    logic        pat_r [N];
    logic        pat_e [N];
    logic        pat_c [N];
    logic [3:0]  exp_code [N];
    logic [3:0]  h_code [N];
    logic [8:0]  h_lat [N];
    logic [31:0] h_cnt [N];
    logic [3:0]  h_cnt4 [N];

    // Strobe code bits: {lat_err, pulse_err, l1, l0}
    localparam logic [3:0] C_L0  = 4'b0001;
    localparam logic [3:0] C_L1  = 4'b0010;
    localparam logic [3:0] C_ERR = 4'b0100;
    localparam logic [3:0] C_L1E = 4'b1010;

    task automatic clear_pat();
        for (int i = 0; i < N; i++) begin
            pat_a[i] = 1'b0;
            pat_r[i] = 1'b0;
            pat_e[i] = 1'b1;
            pat_c[i] = 1'b0;
            exp_code[i] = 4'b0000;
        end
    endtask

    task automatic do_reset();
        @(posedge gclk_40m);
        #1;
        reset = 1'b1;
        ttc_l1accept = 1'b0;
        trig_en = 1'b1;
        cnt_clr = 1'b0;
        @(posedge gclk_40m);
        @(posedge gclk_40m);
        #1;
        reset = 1'b0;
    endtask

    // Cycle i: inputs driven just after posedge i, outputs recorded mid-cycle.
    task automatic play(input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge gclk_40m);
            #1;
            ttc_l1accept = pat_a[i];
            reset = pat_r[i];
            trig_en = pat_e[i];
            cnt_clr = pat_c[i];
            #3;
            h_code[i] = {ttc_l1_lat_err, ttc_pulse_err, ttc_l1, ttc_l0};
            h_lat[i]  = l1_lat;
            h_cnt[i]  = l0_cnt;
            h_cnt4[i] = l0_cnt_4;
        end
        ttc_l1accept = 1'b0;
        reset = 1'b0;
        trig_en = 1'b1;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ttc_l1accept = 1'b1;
        trig_en = 1'b1;
        cnt_clr = 1'b0;
        repeat (3) @(posedge gclk_40m);
        #4;
        checks++;
        if ({ttc_l1_lat_err, ttc_pulse_err, ttc_l1, ttc_l0} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000", {ttc_l1_lat_err, ttc_pulse_err, ttc_l1, ttc_l0});
        else passes++;
        checks++;
        if (l1_lat !== 9'd0) $display("FAIL reset_l1_lat: got %0d want 0", l1_lat);
        else passes++;
        checks++;
        if ({l0_cnt, l1_cnt, err_cnt, l0_cnt_4} !== '0)
            $display("FAIL reset_counters: got l0=%0d l1=%0d err=%0d l0_4=%0d want all 0", l0_cnt, l1_cnt, err_cnt, l0_cnt_4);
        else passes++;
        ttc_l1accept = 1'b0;
    endtask

    task automatic test_l0_l1_window();
        int bad = -1;
        clear_pat();
        pat_a[10] = 1'b1;
        pat_a[259] = 1'b1;
        pat_a[260] = 1'b1;
        exp_code[12] = C_L0;
        exp_code[262] = C_L1;
        do_reset();
        play(270);
        for (int i = 0; i < 270; i++) if (bad < 0 && h_code[i] !== exp_code[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL window_strobes at cycle %0d: got %b want %b", bad, h_code[bad], exp_code[bad]);
        else passes++;
        checks++;
        if (h_lat[262] !== 9'd250) $display("FAIL window_l1_lat: got %0d want 250", h_lat[262]);
        else passes++;
        checks++;
        if (l0_cnt !== 32'd1 || l1_cnt !== 32'd1 || err_cnt !== 32'd0)
            $display("FAIL window_counters: got l0=%0d l1=%0d err=%0d want 1 1 0", l0_cnt, l1_cnt, err_cnt);
        else passes++;
    endtask

    task automatic test_pulse_err();
        int bad = -1;
        clear_pat();
        for (int i = 20; i <= 22; i++) pat_a[i] = 1'b1;
        pat_a[24] = 1'b1;
        for (int i = 40; i <= 46; i++) pat_a[i] = 1'b1;
        for (int i = 60; i <= 67; i++) pat_a[i] = 1'b1;
        exp_code[24] = C_ERR;
        exp_code[26] = C_L0;
        exp_code[48] = C_ERR;
        exp_code[68] = C_ERR;
        do_reset();
        play(80);
        for (int i = 0; i < 80; i++) if (bad < 0 && h_code[i] !== exp_code[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL pulse_err_strobes at cycle %0d: got %b want %b", bad, h_code[bad], exp_code[bad]);
        else passes++;
        checks++;
        if (err_cnt !== 32'd3 || l0_cnt !== 32'd1)
            $display("FAIL pulse_err_counters: got err=%0d l0=%0d want 3 1", err_cnt, l0_cnt);
        else passes++;
    endtask

    task automatic test_stuck();
        int bad = -1;
        clear_pat();
        for (int i = 50; i <= 69; i++) pat_a[i] = 1'b1;
        pat_a[75] = 1'b1;
        exp_code[58] = C_ERR;
        exp_code[77] = C_L0;
        do_reset();
        play(85);
        for (int i = 0; i < 85; i++) if (bad < 0 && h_code[i] !== exp_code[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL stuck_strobes at cycle %0d: got %b want %b", bad, h_code[bad], exp_code[bad]);
        else passes++;
        checks++;
        if (err_cnt !== 32'd1 || l0_cnt !== 32'd1)
            $display("FAIL stuck_counters: got err=%0d l0=%0d want 1 1", err_cnt, l0_cnt);
        else passes++;
    endtask

    task automatic test_latency();
        int bad = -1;
        clear_pat();
        pat_a[5] = 1'b1;
        pat_a[6] = 1'b1;
        pat_a[20] = 1'b1;
        pat_a[119] = 1'b1;
        pat_a[120] = 1'b1;
        pat_a[200] = 1'b1;
        pat_a[489] = 1'b1;
        pat_a[490] = 1'b1;
        exp_code[8] = C_L1E;
        exp_code[22] = C_L0;
        exp_code[122] = C_L1E;
        exp_code[202] = C_L0;
        exp_code[492] = C_L1E;
        do_reset();
        play(500);
        for (int i = 0; i < 500; i++) if (bad < 0 && h_code[i] !== exp_code[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL latency_strobes at cycle %0d: got %b want %b", bad, h_code[bad], exp_code[bad]);
        else passes++;
        checks++;
        if (h_lat[8] !== 9'd0) $display("FAIL orphan_l1_lat: got %0d want 0", h_lat[8]);
        else passes++;
        checks++;
        if (h_lat[122] !== 9'd100) $display("FAIL early_l1_lat: got %0d want 100", h_lat[122]);
        else passes++;
        checks++;
        if (h_lat[150] !== 9'd100) $display("FAIL l1_lat_hold: got %0d want 100", h_lat[150]);
        else passes++;
        checks++;
        if (h_lat[492] !== 9'd0) $display("FAIL late_l1_lat: got %0d want 0", h_lat[492]);
        else passes++;
        checks++;
        if (err_cnt !== 32'd3 || l1_cnt !== 32'd3 || l0_cnt !== 32'd2)
            $display("FAIL latency_counters: got err=%0d l1=%0d l0=%0d want 3 3 2", err_cnt, l1_cnt, l0_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid_run();
        int bad = -1;
        clear_pat();
        pat_a[5] = 1'b1;
        pat_a[6] = 1'b1;
        pat_r[6] = 1'b1;
        pat_a[10] = 1'b1;
        exp_code[12] = C_L0;
        do_reset();
        play(20);
        for (int i = 0; i < 20; i++) if (bad < 0 && h_code[i] !== exp_code[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL reset_mid_strobes at cycle %0d: got %b want %b", bad, h_code[bad], exp_code[bad]);
        else passes++;
        checks++;
        if (h_lat[8] !== 9'd0 || h_cnt[8] !== 32'd0)
            $display("FAIL reset_mid_outputs: got lat=%0d l0=%0d want 0 0", h_lat[8], h_cnt[8]);
        else passes++;
        checks++;
        if (l0_cnt !== 32'd1 || err_cnt !== 32'd0)
            $display("FAIL reset_mid_counters: got l0=%0d err=%0d want 1 0", l0_cnt, err_cnt);
        else passes++;
    endtask

    task automatic test_trig_en();
        int bad = -1;
        clear_pat();
        pat_a[5] = 1'b1;
        pat_a[6] = 1'b1;
        pat_e[6] = 1'b0;
        pat_a[20] = 1'b1;
        pat_e[30] = 1'b0;
        pat_a[98] = 1'b1;
        pat_a[99] = 1'b1;
        exp_code[22] = C_L0;
        exp_code[101] = C_L1E;
        do_reset();
        play(110);
        for (int i = 0; i < 110; i++) if (bad < 0 && h_code[i] !== exp_code[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL trig_en_strobes at cycle %0d: got %b want %b", bad, h_code[bad], exp_code[bad]);
        else passes++;
        checks++;
        if (h_lat[101] !== 9'd0) $display("FAIL trig_en_l1_lat: got %0d want 0", h_lat[101]);
        else passes++;
        checks++;
        if (l0_cnt !== 32'd1 || l1_cnt !== 32'd1 || err_cnt !== 32'd1)
            $display("FAIL trig_en_counters: got l0=%0d l1=%0d err=%0d want 1 1 1", l0_cnt, l1_cnt, err_cnt);
        else passes++;
    endtask

    task automatic test_back_to_back_counters();
        int bad = -1;
        clear_pat();
        for (int k = 0; k < 20; k++) begin
            pat_a[3 * k] = 1'b1;
            exp_code[3 * k + 2] = C_L0;
        end
        pat_a[70] = 1'b1;
        exp_code[72] = C_L0;
        pat_c[72] = 1'b1;
        do_reset();
        play(80);
        for (int i = 0; i < 80; i++) if (bad < 0 && h_code[i] !== exp_code[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL b2b_strobes at cycle %0d: got %b want %b", bad, h_code[bad], exp_code[bad]);
        else passes++;
        checks++;
        if (h_cnt4[60] !== 4'd15) $display("FAIL cnt4_saturate: got %0d want 15", h_cnt4[60]);
        else passes++;
        checks++;
        if (h_cnt[60] !== 32'd20) $display("FAIL cnt32_count: got %0d want 20", h_cnt[60]);
        else passes++;
        checks++;
        if (h_cnt4[72] !== 4'd15) $display("FAIL cnt4_hold_at_max: got %0d want 15", h_cnt4[72]);
        else passes++;
        checks++;
        if (h_cnt4[73] !== 4'd0 || h_cnt[73] !== 32'd0)
            $display("FAIL cnt_clr_wins: got l0_4=%0d l0=%0d want 0 0", h_cnt4[73], h_cnt[73]);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_l0_l1_window();
        test_pulse_err();
        test_stuck();
        test_latency();
        test_reset_mid_run();
        test_trig_en();
        test_back_to_back_counters();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ttc_trig_pulse_decoder.md
Name: ttc_trig_pulse_decoder

Overview:
Parametrised successor to the fixed L0/L1 decoder on the TTC channel-A (L1accept) line. It measures the width of every high run on the single-ended, post-IBUFDS ttc_l1accept signal and classifies it. Widths are programmable: L0_LEN cycles decodes as L0, L1_LEN cycles decodes as L1, anything else is a pulse error, and a run longer than MAX_LEN is a stuck-line error. It also checks the L0→L1 latency window and keeps saturating event and error counters for the SRU status registers.

Parameters:
L0_LEN, 1, high-run length in cycles decoded as L0 (1..MAX_LEN, must differ from L1_LEN)
L1_LEN, 2, high-run length in cycles decoded as L1
MAX_LEN, 7, longest legal run; a longer run is stuck-line
LAT_W, 9, width of the L0→L1 latency counter
L1_LAT_MIN, 240, earliest legal L1, in cycles after ttc_l0
L1_LAT_MAX, 280, latest legal L1 (must be below 2^LAT_W-1)
CNT_W, 32, width of the statistics counters

Ports:
gclk_40m  in  1  system clock, 40 MHz
reset  in  1  synchronous, active-high
ttc_l1accept  in  1  TTC channel A, single-ended, already in the gclk_40m domain
trig_en  in  1  1 = decode enabled; 0 = FSM forced to IDLE, all pulse outputs held 0
cnt_clr  in  1  synchronous clear of all counters
ttc_l0  out  1  one-cycle L0 strobe
ttc_l1  out  1  one-cycle L1 strobe
ttc_pulse_err  out  1  one-cycle strobe: illegal width or stuck line
ttc_l1_lat_err  out  1  one-cycle strobe, coincident with ttc_l1: L1 orphaned or outside the window
l1_lat  out  LAT_W  measured L0→L1 latency, updated with ttc_l1
l0_cnt, l1_cnt, err_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset: all outputs 0, FSM in IDLE, run counter 0, window closed, latency counter 0.
- FSM states:
  - IDLE: a high sample loads run=1 and moves to HIGH.
  - HIGH: a high sample increments run. If run would exceed MAX_LEN, go to STUCK and pulse ttc_pulse_err. A low sample returns to IDLE and classifies the run.
  - STUCK: wait for a low sample, then go to IDLE. Nothing else is decoded and no further errors are raised.
- Timing: input high in cycles t..t+n-1, low at t+n. The classified strobe is high in cycle t+n+1 only.
  - n=L0_LEN gives ttc_l0; n=L1_LEN gives ttc_l1; any other n≤MAX_LEN gives ttc_pulse_err.
  - Stuck case: ttc_pulse_err is high in cycle t+MAX_LEN+1.
- Back-to-back pulses: one low cycle between runs is sufficient. A high sample at t+n+1 starts a new run with no loss.
- At most one of ttc_l0, ttc_l1, ttc_pulse_err is high in any cycle.
- Latency window:
  - The cycle after ttc_l0, the latency counter is loaded with 1 and the window opens. The counter then increments each cycle and saturates at all-ones.
  - The window closes when the counter exceeds L1_LAT_MAX, or when ttc_l1 occurs.
  - A new ttc_l0 while the window is open restarts it.
  - On ttc_l1, l1_lat = the counter value, giving l1_lat = cycle(ttc_l1) − cycle(ttc_l0).
  - ttc_l1_lat_err is set if the window is closed (orphan L1, l1_lat=0) or if the value is below L1_LAT_MIN. ttc_l1 itself is always issued.
- Counters:
  - l0_cnt increments on ttc_l0; l1_cnt on ttc_l1; err_cnt on ttc_pulse_err or ttc_l1_lat_err (+1 per cycle).
  - All counters saturate at 2^CNT_W−1.
  - cnt_clr wins over a simultaneous increment. reset clears the counters.
- trig_en: a falling edge aborts any run in progress with no strobe. The window closes. Counters hold their values.
- Reset mid-run: the run is discarded and no strobe is produced. The first high sample after reset deasserts starts a fresh run.

Decomposition:
- Shared package ttc_pkg: FSM state encoding (IDLE/HIGH/STUCK, one-hot), classification enum (NONE/L0/L1/ERR), default L0_LEN/L1_LEN/MAX_LEN/latency constants.
- Sub-module ttc_pulse_meas: the run-length FSM plus classifier, producing a one-cycle class output.
- Top level: the latency window and the three saturating counters.

Test Plan:
- 1-cycle high at t=10, then 2-cycle high at t=259..260 → ttc_l0@12, ttc_l1@262, l1_lat=250, ttc_l1_lat_err=0, l0_cnt=1, l1_cnt=1.
- 3-cycle high at t=20 → ttc_pulse_err@24 only, err_cnt=1. Follow with a 1-cycle pulse at t=24 → ttc_l0@26.
- 20-cycle high from t=50 → exactly one ttc_pulse_err@58, no other strobe. A 1-cycle pulse after it decodes as L0.
- L1 pulse with no prior L0 → ttc_l1 and ttc_l1_lat_err together, l1_lat=0. L0 then L1 at latency 100 → lat_err=1, l1_lat=100. Latency 290 (>MAX) → lat_err=1, l1_lat=0.
- reset asserted at the second cycle of a 2-cycle pulse → no strobe, all outputs 0. The next 1-cycle pulse gives ttc_l0 two cycles after its rise.
- CNT_W=4 override: 20 L0 pulses → l0_cnt=15. cnt_clr coincident with an ttc_l0 strobe → l0_cnt=0 the next cycle.
